// File: rtl/tremolo_pkg.sv
// tremolo_pkg: shared constants and the LFO clamp helper for the tremolo
// modulator. The LFO word is 0..512, where 512 means "no attenuation".
package tremolo_pkg;

  localparam int LFO_MAX     = 512;
  localparam int LFO_W       = 10;
  localparam int GAIN_W      = 10;
  localparam int GAIN_SHIFT  = 9;
  localparam int DEPTH_SHIFT = 8;

  // Saturate a raw 32-bit LFO word into the legal 0..512 range.
  function automatic logic [LFO_W-1:0] clamp_lfo(input logic [31:0] raw);
    logic [LFO_W-1:0] res;
    if ((|raw[31:10]) || (raw[9:0] > 10'd512)) begin
      res = 10'd512;
    end else begin
      res = raw[9:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/tremolo_modulator_lfo_capture.sv
// lfo_capture: brings the LFO word from the divided-clock domain into CLK.
// The word is clamped, passed through two flops, and only accepted into
// lfo_held once both flops agree, so a word caught mid-change never leaks out.
module lfo_capture
  import tremolo_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [31:0]       lfo_in,
  output logic [LFO_W-1:0]  lfo_held
);

  logic [LFO_W-1:0] s1_r;
  logic [LFO_W-1:0] s2_r;

  // Two-flop capture of the clamped word plus stability-qualified hold register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_r     <= 10'd512;
      s2_r     <= 10'd512;
      lfo_held <= 10'd512;
    end else begin
      s1_r <= clamp_lfo(lfo_in);
      s2_r <= s1_r;
      if (s2_r == s1_r) begin
        lfo_held <= s2_r;
      end else begin
        lfo_held <= lfo_held;
      end
    end
  end

endmodule

// File: rtl/tremolo_modulator.sv
// tremolo_modulator: three-stage amplitude modulation of a signed sample
// stream by a captured LFO word and a depth control.
// Optional build macro TREMOLO_DEPTH_RAMP_EN: depth_cur slews toward depth by
// one step per accepted sample instead of following depth directly.
module tremolo_modulator
  import tremolo_pkg::*;
#(
  parameter int SAMPLE_W = 24
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [31:0]         lfo_in,
  input  logic [7:0]          depth,
  input  logic                enable,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic                out_valid,
  output logic [SAMPLE_W-1:0] sample_out
);

  logic [LFO_W-1:0] lfo_held_s;
  logic [7:0]       depth_cur_s;

  lfo_capture u_lfo_capture (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .lfo_in   (lfo_in),
    .lfo_held (lfo_held_s)
  );

`ifdef TREMOLO_DEPTH_RAMP_EN
  logic [7:0] depth_cur_r;

  // Slew depth_cur one step toward depth on each accepted sample.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      depth_cur_r <= 8'd0;
    end else if (in_valid) begin
      if (depth_cur_r < depth) begin
        depth_cur_r <= depth_cur_r + 8'd1;
      end else if (depth_cur_r > depth) begin
        depth_cur_r <= depth_cur_r - 8'd1;
      end else begin
        depth_cur_r <= depth_cur_r;
      end
    end else begin
      depth_cur_r <= depth_cur_r;
    end
  end

  assign depth_cur_s = depth_cur_r;
`else
  assign depth_cur_s = depth;
`endif

  // Stage 1 registers
  logic                       s1_valid_r;
  logic signed [SAMPLE_W-1:0] s1_sample_r;
  logic                       s1_enable_r;
  logic [LFO_W-1:0]           s1_lfo_r;
  logic [7:0]                 s1_depth_r;

  // Stage 1: accept the sample together with the controls in force at accept.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_valid_r  <= 1'b0;
      s1_sample_r <= {SAMPLE_W{1'b0}};
      s1_enable_r <= 1'b0;
      s1_lfo_r    <= 10'd512;
      s1_depth_r  <= 8'd0;
    end else begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_sample_r <= sample_in;
        s1_enable_r <= enable;
        s1_lfo_r    <= lfo_held_s;
        s1_depth_r  <= depth_cur_s;
      end else begin
        s1_sample_r <= s1_sample_r;
        s1_enable_r <= s1_enable_r;
        s1_lfo_r    <= s1_lfo_r;
        s1_depth_r  <= s1_depth_r;
      end
    end
  end

  logic [LFO_W-1:0]  lfo_room_s;
  logic [17:0]       depth_prod_s;
  logic [GAIN_W-1:0] atten_s;
  logic [GAIN_W-1:0] gain_s;
  logic              unused_depth_bits_s;

  // Gain: 512 minus depth-scaled distance of the LFO from full scale.
  always_comb begin
    lfo_room_s   = 10'd512 - s1_lfo_r;
    depth_prod_s = 18'(s1_depth_r) * 18'(lfo_room_s);
    atten_s      = depth_prod_s[17:DEPTH_SHIFT];
    if (s1_enable_r) begin
      gain_s = 10'd512 - atten_s;
    end else begin
      gain_s = 10'd512;
    end
  end

  assign unused_depth_bits_s = ^depth_prod_s[DEPTH_SHIFT-1:0];

  // Stage 2 registers
  logic                       s2_valid_r;
  logic signed [SAMPLE_W-1:0] s2_sample_r;
  logic [GAIN_W-1:0]          s2_gain_r;

  // Stage 2: hold the sample alongside its computed gain.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s2_valid_r  <= 1'b0;
      s2_sample_r <= {SAMPLE_W{1'b0}};
      s2_gain_r   <= 10'd512;
    end else begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_sample_r <= s1_sample_r;
        s2_gain_r   <= gain_s;
      end else begin
        s2_sample_r <= s2_sample_r;
        s2_gain_r   <= s2_gain_r;
      end
    end
  end

  logic signed [GAIN_W:0]     gain_ext_s;
  logic signed [SAMPLE_W+10:0] prod_s;
  logic                       unused_prod_bits_s;

  // Signed multiply by the zero-extended gain; the >>>9 is a bit select.
  always_comb begin
    gain_ext_s = {1'b0, s2_gain_r};
    prod_s     = s2_sample_r * gain_ext_s;
  end

  assign unused_prod_bits_s = ^{prod_s[SAMPLE_W+10:SAMPLE_W+9], prod_s[GAIN_SHIFT-1:0]};

  // Stage 3: register the scaled sample; output holds between samples.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid  <= 1'b0;
      sample_out <= {SAMPLE_W{1'b0}};
    end else begin
      out_valid <= s2_valid_r;
      if (s2_valid_r) begin
        sample_out <= prod_s[SAMPLE_W+8:GAIN_SHIFT];
      end else begin
        sample_out <= sample_out;
      end
    end
  end

endmodule

// File: tb/tb_tremolo_modulator.sv
// Directed bench for tremolo_modulator with hand-computed expectations.
module tb_tremolo_modulator;

  logic                CLK = 1'b0;
  logic                RST_N;
  logic [31:0]         lfo_in;
  logic [7:0]          depth;
  logic                enable;
  logic                in_valid;
  logic signed [23:0]  sample_in;
  logic                out_valid;
  logic signed [23:0]  sample_out;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  logic signed [23:0] out_q[$];
  int                 out_cyc_q[$];

  tremolo_modulator #(.SAMPLE_W(24)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .lfo_in     (lfo_in),
    .depth      (depth),
    .enable     (enable),
    .in_valid   (in_valid),
    .sample_in  (sample_in),
    .out_valid  (out_valid),
    .sample_out (sample_out)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (out_valid === 1'b1) begin
      out_q.push_back(sample_out);
      out_cyc_q.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic signed [23:0] s, input logic en);
    in_valid  = 1'b1;
    sample_in = s;
    enable    = en;
    step();
    in_valid  = 1'b0;
  endtask

  // Fetch next output, waiting a bounded number of cycles.
  task automatic pop_out(output logic signed [23:0] v, output int c, output bit ok);
    int k = 0;
    while (out_q.size() == 0 && k < 20) begin
      step();
      k++;
    end
    if (out_q.size() == 0) begin
      ok = 1'b0;
      v  = 24'sd0;
      c  = -1;
    end else begin
      ok = 1'b1;
      v  = out_q.pop_front();
      c  = out_cyc_q.pop_front();
    end
  endtask

  task automatic drain();
    repeat (6) step();
    out_q.delete();
    out_cyc_q.delete();
  endtask

  task automatic settle_lfo(input logic [31:0] v);
    lfo_in = v;
    repeat (5) step();
  endtask

  task automatic settle_depth(input logic [7:0] d);
    depth = d;
`ifdef TREMOLO_DEPTH_RAMP_EN
    repeat (260) send(24'sd0, 1'b0);
    drain();
`endif
  endtask

  task automatic test_reset_state();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    tests_run++;
    if (sample_out !== 24'sd0) begin
      tests_failed++;
      $display("FAIL reset_sample_out: got %0d expected 0", sample_out);
    end
  endtask

  // First sample after reset uses lfo_held=512 (unity gain) and appears 3 cycles later.
  task automatic test_first_after_reset();
    logic signed [23:0] got;
    int c, drv;
    bit ok;
    RST_N = 1'b1;
    drv   = cyc;
    send(24'sd1000, 1'b1);
    pop_out(got, c, ok);
    tests_run++;
    if (!ok || got !== 24'sd1000) begin
      tests_failed++;
      $display("FAIL first_after_reset_value: got %0d expected 1000", got);
    end
    tests_run++;
    if (c !== drv + 3) begin
      tests_failed++;
      $display("FAIL first_after_reset_latency: got cycle %0d expected %0d", c, drv + 3);
    end
    drain();
  endtask

  task automatic test_reset_midstream();
    send(24'sh123456, 1'b0);
    send(24'sh123456, 1'b0);
    step();
    #2;
    RST_N = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_out_valid: got %b expected 0", out_valid);
    end
    tests_run++;
    if (sample_out !== 24'sd0) begin
      tests_failed++;
      $display("FAIL midreset_sample_out: got %0d expected 0", sample_out);
    end
    step();
    step();
    RST_N = 1'b1;
    repeat (6) step();
    tests_run++;
    if (out_q.size() != 0) begin
      tests_failed++;
      $display("FAIL midreset_dropped: got %0d outputs expected 0", out_q.size());
    end
    drain();
  endtask

  task automatic test_bypass();
    logic signed [23:0] stim [2] = '{24'sh123456, -24'sh123456};
    logic signed [23:0] got;
    int c;
    bit ok;
    for (int i = 0; i < 2; i++) send(stim[i], 1'b0);
    for (int i = 0; i < 2; i++) begin
      pop_out(got, c, ok);
      tests_run++;
      if (!ok || got !== stim[i]) begin
        tests_failed++;
        $display("FAIL bypass[%0d]: got %0d expected %0d", i, got, stim[i]);
      end
    end
    drain();
  endtask

  // depth 255, lfo 0 -> gain 2
  task automatic test_max_depth();
    logic signed [23:0] stim [2] = '{24'sd1000, -24'sd1000};
    logic signed [23:0] expv [2] = '{24'sd3, -24'sd4};
    logic signed [23:0] got;
    int c;
    bit ok;
    for (int i = 0; i < 2; i++) send(stim[i], 1'b1);
    for (int i = 0; i < 2; i++) begin
      pop_out(got, c, ok);
      tests_run++;
      if (!ok || got !== expv[i]) begin
        tests_failed++;
        $display("FAIL max_depth[%0d]: got %0d expected %0d", i, got, expv[i]);
      end
    end
    drain();
  endtask

  // One-cycle LFO excursion while streaming must never change the gain.
  task automatic test_lfo_glitch();
    logic signed [23:0] got;
    int c;
    bit ok;
    for (int i = 0; i < 8; i++) begin
      in_valid  = 1'b1;
      sample_in = 24'sd1000;
      enable    = 1'b1;
      lfo_in    = (i == 1) ? 32'd512 : 32'd0;
      step();
    end
    in_valid = 1'b0;
    lfo_in   = 32'd0;
    for (int i = 0; i < 8; i++) begin
      pop_out(got, c, ok);
      tests_run++;
      if (!ok || got !== 24'sd3) begin
        tests_failed++;
        $display("FAIL lfo_glitch[%0d]: got %0d expected 3", i, got);
      end
    end
    drain();
  endtask

  // New LFO value takes 3 edges; a sample on the update edge uses the old value.
  task automatic test_lfo_timing();
    logic signed [23:0] expv [5] = '{24'sd3, 24'sd3, 24'sd3, 24'sd1000, 24'sd1000};
    logic signed [23:0] got;
    int c;
    bit ok;
    lfo_in = 32'd512;
    for (int i = 0; i < 5; i++) begin
      in_valid  = 1'b1;
      sample_in = 24'sd1000;
      enable    = 1'b1;
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pop_out(got, c, ok);
      tests_run++;
      if (!ok || got !== expv[i]) begin
        tests_failed++;
        $display("FAIL lfo_timing[%0d]: got %0d expected %0d", i, got, expv[i]);
      end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic signed [23:0] stim [4] = '{24'sd1000, 24'sd1000, -24'sd1000, 24'sh7FFFFF};
    logic               ens  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic signed [23:0] expv [4] = '{24'sd3, 24'sd1000, -24'sd4, 24'sh7FFFFF};
    int drv [4];
    logic signed [23:0] got;
    int c;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      in_valid  = 1'b1;
      sample_in = stim[i];
      enable    = ens[i];
      drv[i]    = cyc;
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pop_out(got, c, ok);
      tests_run++;
      if (!ok || got !== expv[i]) begin
        tests_failed++;
        $display("FAIL stream_value[%0d]: got %0d expected %0d", i, got, expv[i]);
      end
      tests_run++;
      if (c !== drv[i] + 3) begin
        tests_failed++;
        $display("FAIL stream_cycle[%0d]: got %0d expected %0d", i, c, drv[i] + 3);
      end
    end
    repeat (4) step();
    tests_run++;
    if (out_q.size() != 0) begin
      tests_failed++;
      $display("FAIL stream_extra: got %0d extra outputs expected 0", out_q.size());
    end
    drain();
  endtask

  // Out-of-range LFO words saturate to 512 -> unity gain even at depth 255.
  task automatic test_lfo_clamp();
    logic [31:0] lfos [2] = '{32'd600, 32'h0001_0000};
    logic signed [23:0] got;
    int c;
    bit ok;
    for (int i = 0; i < 2; i++) begin
      settle_lfo(lfos[i]);
      send(24'sd1000, 1'b1);
      pop_out(got, c, ok);
      tests_run++;
      if (!ok || got !== 24'sd1000) begin
        tests_failed++;
        $display("FAIL lfo_clamp[%0d]: got %0d expected 1000", i, got);
      end
      drain();
    end
  endtask

  // depth 128, lfo 256 -> gain 384
  task automatic test_mid_depth();
    logic signed [23:0] stim [4] = '{24'sd5120, -24'sd5120, 24'sd1001, -24'sd1001};
    logic signed [23:0] expv [4] = '{24'sd3840, -24'sd3840, 24'sd750, -24'sd751};
    logic signed [23:0] got;
    int c;
    bit ok;
    for (int i = 0; i < 4; i++) send(stim[i], 1'b1);
    for (int i = 0; i < 4; i++) begin
      pop_out(got, c, ok);
      tests_run++;
      if (!ok || got !== expv[i]) begin
        tests_failed++;
        $display("FAIL mid_depth[%0d]: got %0d expected %0d", i, got, expv[i]);
      end
    end
    drain();
  endtask

`ifdef TREMOLO_DEPTH_RAMP_EN
  // With lfo 0 and sample 512, output = 512 - 2*depth_cur (pre-step value).
  task automatic test_depth_ramp();
    logic signed [23:0] got;
    logic signed [23:0] expv;
    int c;
    bit ok;
    depth = 8'd10;
    for (int i = 0; i < 13; i++) begin
      send(24'sd512, 1'b1);
      step();
      step();
    end
    for (int i = 0; i < 13; i++) begin
      expv = (i < 10) ? 24'(512 - 2 * i) : 24'sd492;
      pop_out(got, c, ok);
      tests_run++;
      if (!ok || got !== expv) begin
        tests_failed++;
        $display("FAIL depth_ramp[%0d]: got %0d expected %0d", i, got, expv);
      end
    end
    drain();
  endtask
`endif

  initial begin
    RST_N     = 1'b0;
    lfo_in    = 32'd0;
    depth     = 8'd255;
    enable    = 1'b1;
    in_valid  = 1'b0;
    sample_in = 24'sd0;
    repeat (3) step();
    test_reset_state();
    test_first_after_reset();
    test_reset_midstream();
    settle_lfo(32'd0);
    settle_depth(8'd255);
    test_bypass();
    test_max_depth();
    test_lfo_glitch();
    test_lfo_timing();
    settle_lfo(32'd0);
    test_back_to_back();
    test_lfo_clamp();
    settle_lfo(32'd256);
    settle_depth(8'd128);
    test_mid_depth();
`ifdef TREMOLO_DEPTH_RAMP_EN
    settle_lfo(32'd0);
    settle_depth(8'd0);
    test_depth_ramp();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
